// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared state encoding, defaults and width helper for the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int c_timeout_cyc_def  = 64;
  localparam int c_starve_limit_def = 3;
  localparam int c_state_w          = 3;

  typedef enum logic [c_state_w-1:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_DM = 3'd2,
    RESP_IF = 3'd3,
    RESP_DM = 3'd4
  } arb_state_e;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module : mem_wait_timer
// Brief  : Counts busy cycles; flags expiry on the TIMEOUT_CYC-th enabled cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = c_timeout_cyc_def
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int c_cnt_w = cnt_w(TIMEOUT_CYC);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == c_cnt_w'(TIMEOUT_CYC - 1));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Arbitrates fetch and data-stage accesses onto one memory port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_CYC  = c_timeout_cyc_def,
  parameter int STARVE_LIMIT = c_starve_limit_def
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              timeout_err
);

  localparam int c_sc_w = cnt_w(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [c_sc_w-1:0] starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              timeout_q, timeout_d;

  logic w_timer_clr;
  logic w_timer_en;
  logic w_expired;

  assign w_timer_en = (state_q == BUSY_IF) || (state_q == BUSY_DM);

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (w_timer_clr),
    .enable_i  (w_timer_en),
    .expired_o (w_expired)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    timeout_d   = timeout_q;
    w_timer_clr = 1'b0;

    case (state_q)
      IDLE: begin
        // Data stage wins ties unless fetch has already lost STARVE_LIMIT times.
        if (dm_req && !(if_req && (starve_q == c_sc_w'(STARVE_LIMIT)))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          w_timer_clr = 1'b1;
          if (if_req) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (if_req) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          w_timer_clr = 1'b1;
          starve_d    = '0;
        end
      end
      BUSY_IF: begin
        if (mem_ready || w_expired) begin
          state_d    = RESP_IF;
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem_ready ? mem_rdata : '0;
          timeout_d  = timeout_q | ~mem_ready;
        end
      end
      BUSY_DM: begin
        if (mem_ready || w_expired) begin
          state_d   = RESP_DM;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          dm_ack_d  = 1'b1;
          timeout_d = timeout_q | ~mem_ready;
          if (!mem_ready) begin
            dm_rdata_d = '0;
          end else if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      RESP_IF, RESP_DM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign if_ack      = if_ack_q;
  assign dm_ack      = dm_ack_q;
  assign timeout_err = timeout_q;
  assign if_stall    = if_req & ~if_ack_q;
  assign dm_stall    = dm_req & ~dm_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed scenarios plus randomized traffic against a timeline model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 64;
  localparam int STARVE  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, dm_ack, mem_req, mem_we, if_stall, dm_stall, timeout_err;

  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_if, exp_dm;
  logic          exp_to;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .TIMEOUT_CYC  (TIMEOUT),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_ack      (dm_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .if_stall    (if_stall),
    .dm_stall    (dm_stall),
    .timeout_err (timeout_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_mem_req"}, mem_req, 0);
    check_val({tag, "_mem_we"}, mem_we, 0);
    check_val({tag, "_mem_addr"}, mem_addr, 0);
    check_val({tag, "_mem_wdata"}, mem_wdata, 0);
    check_val({tag, "_if_rdata"}, if_rdata, 0);
    check_val({tag, "_dm_rdata"}, dm_rdata, 0);
    check_val({tag, "_if_ack"}, if_ack, 0);
    check_val({tag, "_dm_ack"}, dm_ack, 0);
    check_val({tag, "_timeout"}, timeout_err, 0);
  endtask

  // Leaves time at 1 unit after a rising edge with the arbiter idle.
  task automatic do_reset();
    reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    exp_if = 0; exp_dm = 0; exp_to = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One isolated transaction from idle; lat >= TIMEOUT means memory never answers.
  task automatic do_xfer(input string tag, input bit is_dm, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input int lat, input bit drop);
    bit to;
    int nb;
    to = (lat >= TIMEOUT);
    nb = to ? TIMEOUT : lat + 1;
    if (is_dm) begin
      dm_req = 1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1; if_addr = addr;
    end
    mem_ready = 0;
    #1 check_val({tag, "_stall_req"}, is_dm ? dm_stall : if_stall, 1);
    for (int k = 1; k <= nb; k++) begin
      @(posedge clk); #1;
      if (drop && k == 1) begin
        if_req = 0; dm_req = 0;
      end
      mem_ready = !to && (k == nb);
      mem_rdata = mem_ready ? rdata : $urandom;
      #1;
      check_val({tag, "_mem_req"}, mem_req, 1);
      check_val({tag, "_mem_we"}, mem_we, is_dm ? we : 1'b0);
      check_val({tag, "_mem_addr"}, mem_addr, addr);
      if (is_dm && we) check_val({tag, "_mem_wdata"}, mem_wdata, wdata);
      check_val({tag, "_no_ack"}, {if_ack, dm_ack}, 0);
    end
    @(posedge clk); #1;
    mem_ready = 0;
    #1;
    if (to) exp_to = 1;
    if (is_dm) begin
      if (to) exp_dm = 0;
      else if (!we) exp_dm = rdata;
    end else begin
      exp_if = to ? '0 : rdata;
    end
    check_val({tag, "_ack"}, {if_ack, dm_ack}, is_dm ? 2'b01 : 2'b10);
    check_val({tag, "_mem_req_off"}, mem_req, 0);
    check_val({tag, "_if_rdata"}, if_rdata, exp_if);
    check_val({tag, "_dm_rdata"}, dm_rdata, exp_dm);
    check_val({tag, "_timeout"}, timeout_err, exp_to);
    check_val({tag, "_stall_ack"}, {if_stall, dm_stall}, 0);
    @(posedge clk); #1;
    if_req = 0; dm_req = 0;
    #1;
    check_val({tag, "_ack_once"}, {if_ack, dm_ack}, 0);
    check_val({tag, "_idle_mem_req"}, mem_req, 0);
  endtask

  task automatic starve_test();
    int n;
    bit exp_dm_win;
    n = 0;
    do_reset();
    if_req = 1; if_addr = 32'h0000_1000;
    dm_req = 1; dm_we = 0; dm_addr = 32'h0000_2000;
    mem_ready = 1;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(posedge clk); #1;
      mem_rdata = $urandom;
      #1;
      if (if_ack || dm_ack) begin
        exp_dm_win = (n % 4) != 3;
        check_val("starve_grant", {if_ack, dm_ack}, exp_dm_win ? 2'b01 : 2'b10);
        n++;
      end
    end
    if (n < 8) check_val("starve_grant_count", n, 8);
    if_req = 0; dm_req = 0; mem_ready = 0;
  endtask

  task automatic reset_midflight_test();
    dm_req = 1; dm_we = 1; dm_addr = 32'h0000_0300; dm_wdata = 32'hA5A5_5A5A;
    mem_ready = 0;
    repeat (2) @(posedge clk);
    #1 check_val("rst_busy_mem_req", mem_req, 1);
    #1 reset = 1'b1;
    #1 check_zero("rst_mid");
    dm_req = 0;
    @(posedge clk); #1 reset = 1'b0;
    exp_if = 0; exp_dm = 0; exp_to = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      check_val("rst_no_ack", dm_ack, 0);
      check_val("rst_no_mem_req", mem_req, 0);
    end
  endtask

  task automatic random_test(input int ncyc);
    int            g_cyc, g_lat, starve;
    bit            active, g_dm, g_we, busy, e_if_ack, e_dm_ack, p_if_ack, p_dm_ack;
    bit            if_want, dm_want, dm_we_r;
    logic [AW-1:0] g_addr, if_a, dm_a;
    logic [DW-1:0] g_wd, g_rd, dm_wd;
    g_cyc = -100; g_lat = 0; starve = 0; active = 0; g_dm = 0; g_we = 0;
    p_if_ack = 0; p_dm_ack = 0; if_want = 0; dm_want = 0; dm_we_r = 0;
    g_addr = 0; if_a = 0; dm_a = 0; g_wd = 0; g_rd = 0; dm_wd = 0;
    do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(posedge clk); #1;
      if (p_if_ack) if_want = 0;
      if (p_dm_ack) dm_want = 0;
      if (!if_want) begin
        if ($urandom_range(0, 2) == 0) begin if_want = 1; if_a = $urandom; end
      end else if ($urandom_range(0, 19) == 0) if_want = 0;
      if (!dm_want) begin
        if ($urandom_range(0, 2) == 0) begin
          dm_want = 1; dm_a = $urandom; dm_wd = $urandom; dm_we_r = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 19) == 0) dm_want = 0;
      if_req = if_want; if_addr = if_a;
      dm_req = dm_want; dm_addr = dm_a; dm_wdata = dm_wd; dm_we = dm_we_r;

      // A transaction granted at cycle g owns cycles g+1 .. g+lat+2; idle again at g+lat+3.
      if (active && cyc >= g_cyc + g_lat + 3) active = 0;
      if (!active && (if_want || dm_want)) begin
        g_dm = dm_want && !(if_want && starve == STARVE);
        if (g_dm) begin
          if (if_want) starve++;
          g_we = dm_we_r; g_addr = dm_a; g_wd = dm_wd;
        end else begin
          starve = 0; g_we = 0; g_addr = if_a;
        end
        g_cyc = cyc; g_lat = $urandom_range(0, 4); g_rd = $urandom; active = 1;
      end
      busy = active && cyc >= g_cyc + 1 && cyc <= g_cyc + 1 + g_lat;
      mem_ready = busy ? (cyc == g_cyc + 1 + g_lat) : 1'($urandom_range(0, 1));
      mem_rdata = (busy && mem_ready) ? g_rd : $urandom;
      e_if_ack = active && cyc == g_cyc + g_lat + 2 && !g_dm;
      e_dm_ack = active && cyc == g_cyc + g_lat + 2 && g_dm;
      if (e_if_ack) exp_if = g_rd;
      if (e_dm_ack && !g_we) exp_dm = g_rd;
      #1;
      check_val("rnd_mem_req", mem_req, busy);
      check_val("rnd_if_ack", if_ack, e_if_ack);
      check_val("rnd_dm_ack", dm_ack, e_dm_ack);
      check_val("rnd_if_rdata", if_rdata, exp_if);
      check_val("rnd_dm_rdata", dm_rdata, exp_dm);
      check_val("rnd_if_stall", if_stall, if_want & ~e_if_ack);
      check_val("rnd_dm_stall", dm_stall, dm_want & ~e_dm_ack);
      check_val("rnd_timeout", timeout_err, 0);
      if (busy) begin
        check_val("rnd_mem_addr", mem_addr, g_addr);
        check_val("rnd_mem_we", mem_we, g_we);
        if (g_we) check_val("rnd_mem_wdata", mem_wdata, g_wd);
      end
      p_if_ack = e_if_ack;
      p_dm_ack = e_dm_ack;
    end
    if_req = 0; dm_req = 0; mem_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    #1 check_zero("reset");
    @(posedge clk); #1;
    do_xfer("fetch_40", 0, 0, 32'h0000_0040, 32'h0, 32'h00A0_0093, 0, 0);
    do_xfer("dm_read", 1, 0, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, 0);
    do_xfer("dm_write", 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 32'hFFFF_0000, 2, 0);
    do_xfer("fetch_drop", 0, 0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 2, 1);
    do_xfer("timeout", 0, 0, 32'h0000_00C0, 32'h0, 32'h1111_2222, TIMEOUT, 0);
    do_xfer("after_to", 1, 0, 32'h0000_0400, 32'h0, 32'h3333_4444, 0, 0);
    reset_midflight_test();
    starve_test();
    random_test(400);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
